lstm_seq_engine: RTL and testbench

- Parametrised successor to the fixed 4-step serial LSTM cell.
- Runs a scalar LSTM over a run-time sequence length of 0..MAX_STEPS.
- Accepts x_t through a valid/ready stream. Emits every h_t/c_t on an output stream with backpressure, then returns the final state.
- One shared multiplier is time-multiplexed across the gates. Fixed point is Q(WIDTH-FRAC).FRAC, default Q7.11.

---
 rtl/lstm_seq_engine_if.sv | 38 +++
 rtl/lstm_seq_engine.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_lstm_seq_engine.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_seq_engine_if.sv
//------------------------------------------------------------------------------
// Module   : lstm_seq_engine_if
// Purpose  : Stream bundle for lstm_seq_engine: the x_t input stream
//            (valid/ready) and the per-step h_t/c_t output stream
//            (valid/ready with backpressure).
// Ports    : x_in/x_valid/x_ready   - input sample stream
//            h_out/c_out/step_idx   - per-step state and 1-based step index
//            out_valid/out_ready    - output stream handshake
//            master modport = stimulus/consumer side, slave = engine side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lstm_seq_engine_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 8
);
  logic signed [WIDTH-1:0] x_in;
  logic                    x_valid;
  logic                    x_ready;
  logic signed [WIDTH-1:0] h_out;
  logic signed [WIDTH-1:0] c_out;
  logic [CNT_W-1:0]        step_idx;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output x_in, x_valid, out_ready,
    input  x_ready, h_out, c_out, step_idx, out_valid
  );

  modport slave (
    input  x_in, x_valid, out_ready,
    output x_ready, h_out, c_out, step_idx, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/lstm_seq_engine.sv
//------------------------------------------------------------------------------
// Module   : lstm_seq_engine
// Purpose  : Scalar LSTM over a run-time sequence of 0..MAX_STEPS steps in
//            Q(WIDTH-FRAC).FRAC fixed point, with one shared multiplier
//            time-multiplexed over the gates (8 gate, 2 cell, 1 hidden cycle).
// Ports    : clk, rst (async, active-low)
//            start/seq_len/c0/h0 and 12 gate weights/biases, latched on start
//            s_if   - x stream in, h/c/step_idx stream out (slave modport)
//            busy, done (1-cycle pulse), c_final/h_final (held until start)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lstm_seq_engine #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 11,
  parameter int MAX_STEPS = 255,
  parameter int CNT_W     = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    start,
  input  wire logic [CNT_W-1:0]        seq_len,
  input  wire logic signed [WIDTH-1:0] c0,
  input  wire logic signed [WIDTH-1:0] h0,
  input  wire logic signed [WIDTH-1:0] W_fx, W_fh, b_f,
  input  wire logic signed [WIDTH-1:0] W_ix, W_ih, b_i,
  input  wire logic signed [WIDTH-1:0] W_gx, W_gh, b_g,
  input  wire logic signed [WIDTH-1:0] W_ox, W_oh, b_o,
  lstm_seq_engine_if.slave             s_if,
  output logic                         busy,
  output logic                         done,
  output logic signed [WIDTH-1:0]      c_final,
  output logic signed [WIDTH-1:0]      h_final
);

  localparam logic signed [2*WIDTH-1:0] SAT_MAX_L = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] SAT_MIN_L = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   ONE       = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0]   HALF      = WIDTH'(1 << (FRAC - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_X, S_GATE, S_CELL, S_HID, S_EMIT, S_FIN
  } state_t;

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH-1:0] v);
    if (v > SAT_MAX_L)      return SAT_MAX;
    else if (v < SAT_MIN_L) return SAT_MIN;
    else                    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sigm(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] t;
    t = (v >>> 2) + HALF;
    if (t < 0)        t = '0;
    else if (t > ONE) t = ONE;
    return t;
  endfunction

  function automatic logic signed [WIDTH-1:0] tanh_clamp(input logic signed [WIDTH-1:0] v);
    if (v > ONE)       return ONE;
    else if (v < -ONE) return -ONE;
    else               return v;
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              sub_q, sub_d;
  logic [CNT_W-1:0]        len_q, len_d, cnt_q, cnt_d;
  // Gate order everywhere: 0=F, 1=I, 2=G, 3=O.
  logic signed [WIDTH-1:0] wx_q [4], wx_d [4];
  logic signed [WIDTH-1:0] wh_q [4], wh_d [4];
  logic signed [WIDTH-1:0] b_q  [4], b_d  [4];
  logic signed [WIDTH-1:0] act_q[4], act_d[4];
  logic signed [WIDTH-1:0] x_q, x_d, p_q, p_d, c_q, c_d, h_q, h_d;
  logic signed [WIDTH-1:0] c_fin_q, c_fin_d, h_fin_q, h_fin_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    x_ready_q, x_ready_d, out_valid_q, out_valid_d;

  logic [1:0]              gi;
  logic signed [WIDTH-1:0] mul_a, mul_b, mul_sat, addend, z, tanh_c;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic signed [WIDTH+1:0] sum;
  logic [CNT_W-1:0]        len_clamped;

  assign gi = sub_q[2:1];
  assign len_clamped = ({1'b0, seq_len} > (CNT_W+1)'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : seq_len;

  // Shared multiplier: operand mux by state/sub-cycle. p_q doubles as the
  // accumulator for the gate pre-activation and for the f*c partial.
  always_comb begin
    tanh_c = tanh_clamp(c_q);
    mul_a  = '0;
    mul_b  = '0;
    addend = '0;
    case (state_q)
      S_GATE: begin
        if (!sub_q[0]) begin
          mul_a = wx_q[gi];
          mul_b = x_q;
        end else begin
          mul_a  = wh_q[gi];
          mul_b  = h_q;
          addend = b_q[gi];
        end
      end
      S_CELL: begin
        if (!sub_q[0]) begin
          mul_a = act_q[0];
          mul_b = c_q;
        end else begin
          mul_a = act_q[1];
          mul_b = act_q[2];
        end
      end
      S_HID: begin
        mul_a = act_q[3];
        mul_b = tanh_c;
      end
      default: ;
    endcase
    prod    = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a}) * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
    prod_sh = prod >>> FRAC;
    mul_sat = sat_w(prod_sh);
    sum     = {{2{p_q[WIDTH-1]}}, p_q} + {{2{mul_sat[WIDTH-1]}}, mul_sat}
            + {{2{addend[WIDTH-1]}}, addend};
    z       = sat_w({{(WIDTH-2){sum[WIDTH+1]}}, sum});
  end

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wx_d        = wx_q;
    wh_d        = wh_q;
    b_d         = b_q;
    act_d       = act_q;
    x_d         = x_q;
    p_d         = p_q;
    c_d         = c_q;
    h_d         = h_q;
    c_fin_d     = c_fin_q;
    h_fin_d     = h_fin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    x_ready_d   = x_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          len_d = len_clamped;
          wx_d  = '{W_fx, W_ix, W_gx, W_ox};
          wh_d  = '{W_fh, W_ih, W_gh, W_oh};
          b_d   = '{b_f, b_i, b_g, b_o};
          c_d   = c0;
          h_d   = h0;
          cnt_d = CNT_W'(1);
          if (len_clamped == '0) begin
            // Empty sequence: initial state is the final state.
            done_d  = 1'b1;
            c_fin_d = c0;
            h_fin_d = h0;
          end else begin
            busy_d    = 1'b1;
            x_ready_d = 1'b1;
            state_d   = S_WAIT_X;
          end
        end
      end
      S_WAIT_X: begin
        if (s_if.x_valid && x_ready_q) begin
          x_d       = s_if.x_in;
          x_ready_d = 1'b0;
          sub_d     = '0;
          state_d   = S_GATE;
        end
      end
      S_GATE: begin
        if (!sub_q[0]) p_d = mul_sat;
        else           act_d[gi] = (gi == 2'd2) ? tanh_clamp(z) : sigm(z);
        sub_d = sub_q + 3'd1;
        if (sub_q == 3'd7) begin
          sub_d   = '0;
          state_d = S_CELL;
        end
      end
      S_CELL: begin
        if (!sub_q[0]) begin
          p_d   = mul_sat;
          sub_d = 3'd1;
        end else begin
          c_d     = z;
          sub_d   = '0;
          state_d = S_HID;
        end
      end
      S_HID: begin
        h_d         = mul_sat;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_valid_q && s_if.out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            c_fin_d = c_q;
            h_fin_d = h_q;
            state_d = S_FIN;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            x_ready_d = 1'b1;
            state_d   = S_WAIT_X;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wx_q        <= '{default: '0};
      wh_q        <= '{default: '0};
      b_q         <= '{default: '0};
      act_q       <= '{default: '0};
      x_q         <= '0;
      p_q         <= '0;
      c_q         <= '0;
      h_q         <= '0;
      c_fin_q     <= '0;
      h_fin_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wx_q        <= wx_d;
      wh_q        <= wh_d;
      b_q         <= b_d;
      act_q       <= act_d;
      x_q         <= x_d;
      p_q         <= p_d;
      c_q         <= c_d;
      h_q         <= h_d;
      c_fin_q     <= c_fin_d;
      h_fin_q     <= h_fin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_ready_q   <= x_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s_if.x_ready   = x_ready_q;
  assign s_if.out_valid = out_valid_q;
  assign s_if.h_out     = h_q;
  assign s_if.c_out     = c_q;
  assign s_if.step_idx  = cnt_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign c_final        = c_fin_q;
  assign h_final        = h_fin_q;

endmodule

`default_nettype wire

// File: tb/tb_lstm_seq_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_lstm_seq_engine
// Purpose  : Directed self-checking bench for lstm_seq_engine. Expected
//            per-step values come from hand-computed constants and a small
//            behavioural model written directly from the cell equations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lstm_seq_engine;
  localparam int WIDTH     = 18;
  localparam int FRAC      = 11;
  localparam int MAX_STEPS = 255;
  localparam int CNT_W     = 8;
  localparam longint SMAX  = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint SMIN  = -(longint'(1) <<< (WIDTH - 1));
  localparam longint M_ONE = longint'(1) <<< FRAC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    start;
  logic [CNT_W-1:0]        seq_len;
  logic signed [WIDTH-1:0] c0, h0;
  logic signed [WIDTH-1:0] W_fx, W_fh, b_f, W_ix, W_ih, b_i;
  logic signed [WIDTH-1:0] W_gx, W_gh, b_g, W_ox, W_oh, b_o;
  logic                    busy, done;
  logic signed [WIDTH-1:0] c_final, h_final;

  lstm_seq_engine_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  lstm_seq_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .c0(c0), .h0(h0),
    .W_fx(W_fx), .W_fh(W_fh), .b_f(b_f), .W_ix(W_ix), .W_ih(W_ih), .b_i(b_i),
    .W_gx(W_gx), .W_gh(W_gh), .b_g(b_g), .W_ox(W_ox), .W_oh(W_oh), .b_o(b_o),
    .s_if(ifc), .busy(busy), .done(done), .c_final(c_final), .h_final(h_final)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, ov_cnt = 0, xr_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1)          done_cnt <= done_cnt + 1;
    if (ifc.out_valid === 1'b1) ov_cnt   <= ov_cnt + 1;
    if (ifc.x_ready === 1'b1)   xr_cnt   <= xr_cnt + 1;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [WIDTH-1:0] q(input longint v);
    return v[WIDTH-1:0];
  endfunction

  // ---------------- reference model ----------------
  longint mwx[4], mwh[4], mb[4];

  function automatic longint m_sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction
  function automatic longint m_mul(input longint a, input longint b);
    return m_sat((a * b) >>> FRAC);
  endfunction
  function automatic longint m_sig(input longint v);
    longint t;
    t = (v >>> 2) + (M_ONE >>> 1);
    if (t < 0) t = 0;
    if (t > M_ONE) t = M_ONE;
    return t;
  endfunction
  function automatic longint m_tanh(input longint v);
    if (v > M_ONE) return M_ONE;
    if (v < -M_ONE) return -M_ONE;
    return v;
  endfunction

  task automatic model_step(input longint x, inout longint c, inout longint h);
    longint act[4];
    longint p, zz;
    for (int g = 0; g < 4; g++) begin
      p  = m_mul(mwx[g], x);
      zz = m_sat(p + m_mul(mwh[g], h) + mb[g]);
      act[g] = (g == 2) ? m_tanh(zz) : m_sig(zz);
    end
    c = m_sat(m_mul(act[0], c) + m_mul(act[1], act[2]));
    h = m_mul(act[3], m_tanh(c));
  endtask

  task automatic model_load();
    mwx = '{longint'(W_fx), longint'(W_ix), longint'(W_gx), longint'(W_ox)};
    mwh = '{longint'(W_fh), longint'(W_ih), longint'(W_gh), longint'(W_oh)};
    mb  = '{longint'(b_f),  longint'(b_i),  longint'(b_g),  longint'(b_o)};
  endtask

  // ---------------- stimulus helpers ----------------
  longint xs[4];
  int     gaps[4];

  task automatic set_weights();
    W_fx = q(1024);  W_fh = q(512);   b_f = q(3318);
    W_ix = q(-768);  W_ih = q(256);   b_i = q(1269);
    W_gx = q(1536);  W_gh = q(-1024); b_g = q(-655);
    W_ox = q(640);   W_oh = q(384);   b_o = q(1208);
  endtask

  task automatic zero_weights();
    W_fx = '0; W_fh = '0; b_f = '0; W_ix = '0; W_ih = '0; b_i = '0;
    W_gx = '0; W_gh = '0; b_g = '0; W_ox = '0; W_oh = '0; b_o = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_x(input longint x, input int gap, output bit ok);
    int n = 0;
    if (gap > 0) begin
      ifc.x_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    ifc.x_in    = q(x);
    ifc.x_valid = 1'b1;
    while (!ifc.x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = ifc.x_ready;
    @(negedge clk);
    if (gap > 0) ifc.x_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!ifc.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ifc.out_valid;
  endtask

  // Runs one sequence of n steps from the current c0/h0/weights, checking each
  // beat against the model. bp_step holds out_ready low for 20 cycles on that
  // step; dbl_start pulses a competing start during that step.
  task automatic run_seq(input string tg, input int n, input int bp_step, input int dbl_start);
    longint mc, mh;
    bit ok;
    int n_wait;
    mc = longint'(c0);
    mh = longint'(h0);
    model_load();
    seq_len = CNT_W'(n);
    do_start();
    check_val({tg, "_busy"}, longint'(busy), 1);
    for (int s = 0; s < n; s++) begin
      model_step(xs[s], mc, mh);
      send_x(xs[s], gaps[s], ok);
      if (!ok) begin
        check_val({tg, "_x_timeout"}, 0, 1);
        return;
      end
      if (s == dbl_start) begin
        start = 1'b1; seq_len = CNT_W'(1); c0 = q(777); b_f = '0; W_fx = q(-5000);
        @(negedge clk);
        start = 1'b0;
      end
      if (s == bp_step) ifc.out_ready = 1'b0;
      wait_out(ok);
      if (!ok) begin
        check_val({tg, "_out_timeout"}, 0, 1);
        return;
      end
      check_val({tg, "_h_out"}, longint'(ifc.h_out), mh);
      check_val({tg, "_c_out"}, longint'(ifc.c_out), mc);
      check_val({tg, "_step_idx"}, longint'(ifc.step_idx), s + 1);
      if (s == bp_step) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check_val({tg, "_hold"},
                    longint'({ifc.out_valid, ifc.x_ready, ifc.step_idx, ifc.h_out, ifc.c_out}),
                    longint'({1'b1, 1'b0, CNT_W'(s + 1), WIDTH'(mh), WIDTH'(mc)}));
        end
        ifc.out_ready = 1'b1;
      end
      @(negedge clk);
      check_val({tg, "_ov_drop"}, longint'(ifc.out_valid), 0);
    end
    ifc.x_valid = 1'b0;
    n_wait = 0;
    while (!done && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    check_val({tg, "_done"}, longint'(done), 1);
    check_val({tg, "_busy_at_done"}, longint'(busy), 0);
    check_val({tg, "_c_final"}, longint'(c_final), mc);
    check_val({tg, "_h_final"}, longint'(h_final), mh);
    @(negedge clk);
    check_val({tg, "_done_pulse"}, longint'(done), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d_snap, ov_snap, xr_snap;

    start = 1'b0; seq_len = '0; c0 = '0; h0 = '0;
    set_weights();
    ifc.x_in = '0; ifc.x_valid = 1'b0; ifc.out_ready = 1'b1;
    xs = '{0, 0, 0, 0};
    gaps = '{0, 0, 0, 0};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_done", longint'(done), 0);
    check_val("rst_x_ready", longint'(ifc.x_ready), 0);
    check_val("rst_out_valid", longint'(ifc.out_valid), 0);
    check_val("rst_c_final", longint'(c_final), 0);
    check_val("rst_step_idx", longint'(ifc.step_idx), 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-input single step, hand values: c=-429, h=-278
    c0 = '0; h0 = '0; xs[0] = 0;
    run_seq("zin", 1, -1, -1);
    check_val("zin_c_hand", longint'(c_final), -429);
    check_val("zin_h_hand", longint'(h_final), -278);

    // Four-step regression, no stalls
    xs = '{0, 1024, 512, 2048};
    gaps = '{0, 0, 0, 0};
    c0 = '0; h0 = '0;
    run_seq("reg", 4, -1, -1);

    // Same sequence with x gaps, backpressure on step 3, ignored start on step 1
    gaps = '{3, 7, 0, 5};
    c0 = '0; h0 = '0;
    run_seq("stall", 4, 2, 0);
    set_weights();
    gaps = '{0, 0, 0, 0};

    // Zero-length sequence
    c0 = q(300); h0 = q(-200); seq_len = '0;
    d_snap = done_cnt; ov_snap = ov_cnt; xr_snap = xr_cnt;
    do_start();
    check_val("zl_done", longint'(done), 1);
    check_val("zl_busy", longint'(busy), 0);
    check_val("zl_c_final", longint'(c_final), 300);
    check_val("zl_h_final", longint'(h_final), -200);
    repeat (5) @(negedge clk);
    check_val("zl_done_count", done_cnt - d_snap, 1);
    check_val("zl_no_out_valid", ov_cnt - ov_snap, 0);
    check_val("zl_no_x_ready", xr_cnt - xr_snap, 0);

    // Saturation: z_f clamps, f=1.0, c passes through, h=(1024*1000)>>11=500
    zero_weights();
    W_fx = q(131071); b_f = q(131071);
    c0 = q(1000); h0 = '0; xs[0] = 131071;
    run_seq("sat", 1, -1, -1);
    check_val("sat_c_hand", longint'(c_final), 1000);
    check_val("sat_h_hand", longint'(h_final), 500);

    // Reset during GATE of step 2
    set_weights();
    xs = '{0, 1024, 512, 2048};
    c0 = '0; h0 = '0; seq_len = CNT_W'(3);
    do_start();
    send_x(xs[0], 0, ok);
    wait_out(ok);
    check_val("rst_mid_first_beat", longint'(ok), 1);
    @(negedge clk);
    send_x(xs[1], 0, ok);
    check_val("rst_mid_x2_taken", longint'(ok), 1);
    d_snap = done_cnt;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid_busy", longint'(busy), 0);
    check_val("rst_mid_out_valid", longint'(ifc.out_valid), 0);
    check_val("rst_mid_x_ready", longint'(ifc.x_ready), 0);
    check_val("rst_mid_h_out", longint'(ifc.h_out), 0);
    check_val("rst_mid_c_out", longint'(ifc.c_out), 0);
    check_val("rst_mid_step_idx", longint'(ifc.step_idx), 0);
    check_val("rst_mid_c_final", longint'(c_final), 0);
    check_val("rst_mid_h_final", longint'(h_final), 0);
    ifc.x_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_mid_no_done", done_cnt - d_snap, 0);

    // Clean run after reset release
    c0 = '0; h0 = '0; xs[0] = 0;
    run_seq("post_rst", 1, -1, -1);
    check_val("post_rst_c_hand", longint'(c_final), -429);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
